// File: rtl/led_addr_seq.sv
// led_addr_seq: steps a 12-bit pattern-ROM address at a prescaled rate and
// latches the 4-bit ROM word into a registered LED output. The ROM has one
// cycle of read latency, so every address change is followed by a two-stage
// pending pipeline before the LED register is loaded and step pulses.
module led_addr_seq #(
  parameter int          PRESCALE   = 50000000,
  parameter logic [11:0] START_ADDR = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        dir,
  input  logic        clr,
  input  logic [3:0]  rom_data,
  output logic [11:0] addr,
  output logic        rom_en,
  output logic [3:0]  led,
  output logic        step
);

  localparam int          CNT_W   = 26;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [11:0]        addr_q, addr_d;
  logic               pend_a_q, pend_a_d;  // address changed, ROM samples it this cycle
  logic               pend_b_q, pend_b_d;  // rom_data is valid this cycle
  logic [3:0]         led_q, led_d;
  logic               step_q, step_d;
  logic               tick;

  // Next-state, prescaler, address stepping and load pipeline; clr overrides all.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    led_d    = led_q;
    step_d   = 1'b0;
    tick     = (state_q == RUN) && (cnt_q == CNT_MAX);
    pend_a_d = tick;
    // PRIME presents START_ADDR to the ROM, so its word is ready one cycle later.
    pend_b_d = pend_a_q || (state_q == PRIME);

    case (state_q)
      IDLE: begin
        if (run) state_d = PRIME;
      end
      PRIME: begin
        state_d = RUN;
      end
      RUN: begin
        if (!run) state_d = HOLD;
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
      end
      HOLD: begin
        // Counter is frozen here so stepping resumes mid-interval.
        if (run) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase

    if (tick) begin
      addr_d = dir ? (addr_q - 12'd1) : (addr_q + 12'd1);
    end

    // An in-flight load completes regardless of run.
    if (pend_b_q) begin
      led_d  = rom_data;
      step_d = 1'b1;
    end

    if (clr) begin
      state_d  = IDLE;
      addr_d   = START_ADDR;
      cnt_d    = '0;
      pend_a_d = 1'b0;
      pend_b_d = 1'b0;
      led_d    = 4'h0;
      step_d   = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset taking precedence.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= START_ADDR;
      pend_a_q <= 1'b0;
      pend_b_q <= 1'b0;
      led_q    <= 4'h0;
      step_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      pend_a_q <= pend_a_d;
      pend_b_q <= pend_b_d;
      led_q    <= led_d;
      step_q   <= step_d;
    end
  end

  assign addr   = addr_q;
  assign rom_en = (state_q != IDLE);
  assign led    = led_q;
  assign step   = step_q;

endmodule

// File: tb/tb_led_addr_seq.sv
// Bench for led_addr_seq: event-queue reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_led_addr_seq;

  localparam int          P  = 4;
  localparam logic [11:0] SA = 12'h000;

  localparam int M_IDLE  = 0;
  localparam int M_PRIME = 1;
  localparam int M_RUN   = 2;
  localparam int M_HOLD  = 3;

  logic        clk = 1'b0;
  logic        rst, run, dir, clr;
  logic [3:0]  rom_data;
  logic [11:0] addr;
  logic        rom_en;
  logic [3:0]  led;
  logic        step;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  led_addr_seq #(.PRESCALE(P), .START_ADDR(SA)) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .dir      (dir),
    .clr      (clr),
    .rom_data (rom_data),
    .addr     (addr),
    .rom_en   (rom_en),
    .led      (led),
    .step     (step)
  );

  // Pattern ROM: one-hot of the low address bits, 1-cycle latency, 0 when disabled.
  always @(posedge clk) rom_data <= rom_en ? (4'b0001 << addr[1:0]) : 4'h0;

  function automatic logic [3:0] rom_f(input logic [11:0] a);
    return 4'b0001 << a[1:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: scheduled LED loads live in a queue keyed by due cycle.
  typedef struct {
    int         due;
    logic [3:0] val;
  } load_t;

  load_t       lq[$];
  bit          m_valid = 1'b0;
  int          m_mode  = M_IDLE;
  int          m_cnt   = 0;
  logic [11:0] m_addr  = SA;
  logic [3:0]  m_led   = 4'h0;
  bit          m_step  = 1'b0;

  always @(posedge clk) begin
    bit tk;
    if (rst === 1'b1 || (m_valid && clr === 1'b1)) begin
      m_valid = 1'b1;
      m_mode  = M_IDLE;
      m_cnt   = 0;
      m_addr  = SA;
      m_led   = 4'h0;
      m_step  = 1'b0;
      lq.delete();
    end else if (m_valid) begin
      tk     = (m_mode == M_RUN) && (m_cnt == P - 1);
      m_step = 1'b0;
      if (lq.size() > 0 && lq[0].due == cyc + 1) begin
        m_led  = lq[0].val;
        m_step = 1'b1;
        void'(lq.pop_front());
      end
      if (m_mode == M_PRIME) lq.push_back('{due: cyc + 2, val: rom_f(m_addr)});
      if (tk) begin
        m_addr = dir ? (m_addr - 12'd1) : (m_addr + 12'd1);
        lq.push_back('{due: cyc + 3, val: rom_f(m_addr)});
      end
      if (m_mode == M_RUN) m_cnt = tk ? 0 : m_cnt + 1;
      case (m_mode)
        M_IDLE:  if (run) m_mode = M_PRIME;
        M_PRIME: m_mode = M_RUN;
        M_RUN:   if (!run) m_mode = M_HOLD;
        default: if (run) m_mode = M_RUN;
      endcase
    end
    cyc++;
    #2;
    if (m_valid) begin
      chk("model_addr",   addr,   m_addr);
      chk("model_rom_en", rom_en, (m_mode != M_IDLE));
      chk("model_led",    led,    m_led);
      chk("model_step",   step,   m_step);
    end
  end

  task automatic wait_step(input string name, input int maxc, output int at);
    at = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (step === 1'b1) begin
        at = cyc;
        break;
      end
    end
    chk({name, "_seen"}, (at >= 0), 1);
  endtask

  task automatic wait_addr_chg(input string name, input int maxc);
    logic [11:0] old;
    bit          seen;
    old  = addr;
    seen = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (addr !== old) begin
        seen = 1'b1;
        break;
      end
    end
    chk({name, "_seen"}, seen, 1);
  endtask

  task automatic wait_addr_eq(input string name, input logic [11:0] target, input int maxc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (addr === target) begin
        seen = 1'b1;
        break;
      end
    end
    chk({name, "_seen"}, seen, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] exp_seq [4];
    int         t, prev, nsteps;

    exp_seq[0] = 4'h2; exp_seq[1] = 4'h4; exp_seq[2] = 4'h8; exp_seq[3] = 4'h1;
    rst = 1'b1; run = 1'b0; dir = 1'b0; clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_addr",   addr,   12'h000);
    chk("rst_led",    led,    4'h0);
    chk("rst_step",   step,   1'b0);
    chk("rst_rom_en", rom_en, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_rom_en", rom_en, 1'b0);

    // Increment run: PRIME, first pattern, then one step every P cycles.
    run = 1'b1;
    @(negedge clk);
    chk("prime_rom_en", rom_en, 1'b1);
    wait_step("first_step", 10, t);
    chk("first_led", led, 4'h1);
    @(negedge clk);
    chk("first_pulse_end", step, 1'b0);
    prev = t;
    for (int k = 0; k < 4; k++) begin
      wait_step("inc_step", 10, t);
      chk("inc_led", led, exp_seq[k]);
      if (k > 0) chk("inc_gap", t - prev, P);
      prev = t;
      @(negedge clk);
      chk("inc_pulse_end", step, 1'b0);
    end

    // Drop run with the counter about to freeze at 2; in-flight load still lands.
    repeat (2) @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    chk("hold_inflight_step", step, 1'b1);
    chk("hold_inflight_led",  led,  4'h2);
    chk("hold_addr0",         addr, 12'h005);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_addr", addr, 12'h005);
      chk("hold_step", step, 1'b0);
    end
    run = 1'b1;
    @(negedge clk);
    chk("resume_addr1", addr, 12'h005);
    @(negedge clk);
    chk("resume_addr2", addr, 12'h005);
    @(negedge clk);
    chk("resume_addr3", addr, 12'h006);

    // Drop run in the cycle right after a tick: exactly one more step.
    run = 1'b0;
    nsteps = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (step === 1'b1) nsteps++;
    end
    chk("drop_after_tick_steps", nsteps, 1);
    chk("drop_after_tick_led",   led,    4'h4);
    chk("drop_after_tick_addr",  addr,   12'h006);

    // clr together with run goes to IDLE first, then decrement run from 0.
    dir = 1'b1; run = 1'b1; clr = 1'b1;
    @(negedge clk);
    chk("clr_run_rom_en", rom_en, 1'b0);
    chk("clr_run_addr",   addr,   12'h000);
    chk("clr_run_led",    led,    4'h0);
    clr = 1'b0;
    @(negedge clk);
    chk("clr_run_prime", rom_en, 1'b1);
    wait_step("dec_step0", 10, t);
    chk("dec_led0",  led,  4'h1);
    chk("dec_addr0", addr, 12'h000);
    wait_step("dec_step1", 10, t);
    chk("dec_led1",  led,  4'h8);
    chk("dec_addr1", addr, 12'hFFF);
    wait_step("dec_step2", 10, t);
    chk("dec_led2",  led,  4'h4);
    chk("dec_addr2", addr, 12'hFFE);

    // clr while a load is in flight.
    wait_addr_chg("clr_pend_tick", 10);
    clr = 1'b1;
    @(negedge clk);
    chk("clr_pend_addr",   addr,   12'h000);
    chk("clr_pend_led",    led,    4'h0);
    chk("clr_pend_rom_en", rom_en, 1'b0);
    chk("clr_pend_step",   step,   1'b0);
    clr = 1'b0; run = 1'b0; dir = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("clr_pend_no_step", step, 1'b0);
    end

    // Reset mid-pipeline at address 5, alone and together with clr.
    for (int k = 0; k < 2; k++) begin
      run = 1'b1;
      wait_addr_eq("rst_mid_addr5", 12'h005, 60);
      rst = 1'b1;
      clr = (k == 1);
      @(negedge clk);
      chk("rst_mid_addr",   addr,   12'h000);
      chk("rst_mid_led",    led,    4'h0);
      chk("rst_mid_step",   step,   1'b0);
      chk("rst_mid_rom_en", rom_en, 1'b0);
      rst = 1'b0; clr = 1'b0; run = 1'b0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        chk("rst_mid_no_step", step,   1'b0);
        chk("rst_mid_idle",    rom_en, 1'b0);
      end
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
